// File: rtl/gmm_params_writeback.sv
// GMM parameter writer: buffers per-pixel cluster records and bursts them to frame memory
// as three 64-bit beats per pixel. Define GMM_WRITEBACK_CHECKSUM_EN to add a per-pixel XOR byte.
module gmm_params_writeback #(
  parameter int BURST_PIXELS = 8,
  parameter int FIFO_DEPTH   = 32,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [23:0]       frame_pixels,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic [5:0]        snk_u,
  input  logic [1:0]        snk_clusters_num,
  input  logic [71:0]       snk_mem_color,
  input  logic [47:0]       snk_mem_var,
  input  logic [23:0]       snk_mem_w,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [63:0]       avm_writedata,
  output logic [7:0]        avm_byteenable,
  output logic [7:0]        avm_burstcount,
  input  logic              avm_waitrequest
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int REC_W = 152;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_BURST, S_DONE} state_e;

  state_e state_q, state_d;

  logic [REC_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    cnt_q;
  logic [23:0]       acc_q, acc_d;
  logic [23:0]       frame_q, frame_d;
  logic [23:0]       remain_q, remain_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        bcount_q, bcount_d;
  logic [7:0]        bpix_q, bpix_d;
  logic [7:0]        left_q, left_d;
  logic [1:0]        beat_q, beat_d;

  logic              fifo_full, push, pop, accept, fill_ok;
  logic [7:0]        need;
  logic [23:0]       frame_eff;
  logic [REC_W-1:0]  head;
  logic [5:0]        h_u;
  logic [1:0]        h_cn;
  logic [71:0]       h_color;
  logic [47:0]       h_var;
  logic [23:0]       h_w;
  logic [7:0]        top2;
  logic [63:0]       beat_data;

  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);
  assign avm_write  = (state_q == S_BURST);
  assign fifo_full  = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign snk_ready  = busy && !fifo_full && (acc_q < frame_q);
  assign push       = snk_valid && snk_ready;
  assign accept     = avm_write && !avm_waitrequest;
  assign pop        = accept && (beat_q == 2'd2);

  assign need      = (remain_q < 24'(BURST_PIXELS)) ? remain_q[7:0] : 8'(BURST_PIXELS);
  assign fill_ok   = (24'(cnt_q) >= 24'(need));
  assign frame_eff = (frame_pixels == 24'd0) ? 24'd1 : frame_pixels;

  assign avm_address    = addr_q;
  assign avm_burstcount = bcount_q;
  assign avm_byteenable = avm_write ? 8'hFF : 8'h00;
  assign avm_writedata  = avm_write ? beat_data : '0;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {snk_u, snk_clusters_num, snk_mem_color, snk_mem_var, snk_mem_w};
  end

  assign head = fifo_mem[rd_ptr_q];
  assign {h_u, h_cn, h_color, h_var, h_w} = head;

`ifdef GMM_WRITEBACK_CHECKSUM_EN
  // Payload bytes of all three beats reduce to every field of the record once.
  always_comb begin
    top2 = {h_u, h_cn};
    for (int unsigned i = 0; i < 9; i++) top2 = top2 ^ h_color[i*8 +: 8];
    for (int unsigned i = 0; i < 6; i++) top2 = top2 ^ h_var[i*8 +: 8];
    for (int unsigned i = 0; i < 3; i++) top2 = top2 ^ h_w[i*8 +: 8];
  end
`else
  assign top2 = '0;
`endif

  always_comb begin
    beat_data = '0;
    case (beat_q)
      2'd0:    beat_data = {8'h00, h_u, h_cn, h_var[15:0], h_w[7:0], h_color[23:0]};
      2'd1:    beat_data = {16'h0000, h_var[31:16], h_w[15:8], h_color[47:24]};
      default: beat_data = {top2, 8'h00, h_var[47:32], h_w[23:16], h_color[71:48]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    frame_d  = frame_q;
    remain_d = remain_q;
    addr_d   = addr_q;
    bcount_d = bcount_q;
    bpix_d   = bpix_q;
    left_d   = left_q;
    beat_d   = beat_q;
    if (push) acc_d = acc_q + 24'd1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          frame_d  = frame_eff;
          remain_d = frame_eff;
          acc_d    = '0;
          beat_d   = '0;
          state_d  = S_FILL;
        end
      end
      S_FILL: begin
        if (fill_ok) begin
          bpix_d   = need;
          left_d   = need;
          bcount_d = 8'(need * 8'd3);
          beat_d   = '0;
          state_d  = S_BURST;
        end
      end
      S_BURST: begin
        if (accept) begin
          if (beat_q == 2'd2) begin
            beat_d = '0;
            left_d = left_q - 8'd1;
            if (left_q == 8'd1) begin
              addr_d   = addr_q + ADDR_W'(13'(bpix_q) * 13'd24);
              remain_d = remain_q - 24'(bpix_q);
              state_d  = (remain_q == 24'(bpix_q)) ? S_DONE : S_FILL;
            end
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      frame_q  <= '0;
      remain_q <= '0;
      addr_q   <= '0;
      bcount_q <= '0;
      bpix_q   <= '0;
      left_q   <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      frame_q  <= frame_d;
      remain_q <= remain_d;
      addr_q   <= addr_d;
      bcount_q <= bcount_d;
      bpix_q   <= bpix_d;
      left_q   <= left_d;
      beat_q   <= beat_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_gmm_params_writeback.sv
// Bench for gmm_params_writeback: frame scenarios from a table, checked beat-by-beat
// against a reference of pixel addresses and beat packing, plus a mid-burst reset sequence.
module tb_gmm_params_writeback;

  localparam int BP = 8;
  localparam int FD = 32;
  localparam int AW = 32;

  logic          clk, rst_n;
  logic [AW-1:0] base_addr;
  logic [23:0]   frame_pixels;
  logic          start, busy, frame_done;
  logic          snk_valid, snk_ready;
  logic [5:0]    snk_u;
  logic [1:0]    snk_clusters_num;
  logic [71:0]   snk_mem_color;
  logic [47:0]   snk_mem_var;
  logic [23:0]   snk_mem_w;
  logic [AW-1:0] avm_address;
  logic          avm_write;
  logic [63:0]   avm_writedata;
  logic [7:0]    avm_byteenable, avm_burstcount;
  logic          avm_waitrequest;

  gmm_params_writeback #(.BURST_PIXELS(BP), .FIFO_DEPTH(FD), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .base_addr(base_addr), .frame_pixels(frame_pixels),
    .start(start), .busy(busy), .frame_done(frame_done),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_u(snk_u),
    .snk_clusters_num(snk_clusters_num), .snk_mem_color(snk_mem_color),
    .snk_mem_var(snk_mem_var), .snk_mem_w(snk_mem_w),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  u;
    logic [1:0]  cn;
    logic [71:0] color;
    logic [47:0] vr;
    logic [23:0] w;
  } rec_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  bc;
    logic [63:0] data;
  } beat_t;

  // wmode: 0 no wait, 1 random wait, 2 five-cycle stall on beat 7, 3 wait held for 80 cycles
  typedef struct {
    logic [31:0] base;
    int unsigned fp;
    int unsigned wmode;
    bit          gaps;
    bit          restart;
    bit          pat;
    int unsigned exp_beats;
    logic [31:0] exp_last_addr;
    logic [7:0]  exp_last_bc;
    bit          chk_lat;
  } vec_t;

  int    tests = 0;
  int    fails = 0;
  rec_t  px[$];
  beat_t exp_q[$];
  beat_t obs_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] pack_raw(input rec_t r, input int unsigned k);
    logic [63:0] d;
    d = '0;
    d[23:0]  = r.color[k*24 +: 24];
    d[31:24] = r.w[k*8 +: 8];
    d[47:32] = r.vr[k*16 +: 16];
    if (k == 0) d[55:48] = {r.u, r.cn};
    return d;
  endfunction

  function automatic logic [63:0] pack(input rec_t r, input int unsigned k);
    logic [63:0] d;
    d = pack_raw(r, k);
`ifdef GMM_WRITEBACK_CHECKSUM_EN
    if (k == 2) begin
      logic [63:0] b0, b1, b2;
      logic [7:0]  x;
      b0 = pack_raw(r, 0);
      b1 = pack_raw(r, 1);
      b2 = pack_raw(r, 2);
      x = '0;
      for (int i = 0; i < 7; i++) x = x ^ b0[i*8 +: 8];
      for (int i = 0; i < 6; i++) x = x ^ b1[i*8 +: 8] ^ b2[i*8 +: 8];
      d[63:56] = x;
    end
`endif
    return d;
  endfunction

  task automatic gen_pixels(input int unsigned n, input bit pat);
    rec_t        r;
    logic [95:0] t;
    px.delete();
    for (int i = 0; i < int'(n) + 3; i++) begin
      if (pat) begin
        r.u = '0; r.cn = '0; r.vr = '0; r.w = '0;
        r.color = 72'h09_08_07_06_05_04_03_02_01;
      end else begin
        t = {$urandom(), $urandom(), $urandom()};
        r.color = t[71:0];
        t = {$urandom(), $urandom(), $urandom()};
        r.vr = t[47:0];
        r.w  = t[71:48];
        r.u  = t[77:72];
        r.cn = t[79:78];
      end
      px.push_back(r);
    end
  endtask

  task automatic build_exp(input logic [31:0] base, input int unsigned eff);
    beat_t       b;
    int unsigned first, n;
    exp_q.delete();
    for (int unsigned p = 0; p < eff; p++) begin
      first = (p / BP) * BP;
      n = (eff - first < BP) ? eff - first : BP;
      for (int unsigned k = 0; k < 3; k++) begin
        b.addr = base + 32'(24 * first);
        b.bc   = 8'(3 * n);
        b.data = pack(px[p], k);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic drive_px(input int unsigned i);
    snk_u            = px[i].u;
    snk_clusters_num = px[i].cn;
    snk_mem_color    = px[i].color;
    snk_mem_var      = px[i].vr;
    snk_mem_w        = px[i].w;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int unsigned eff, nb1, accepted, beats, done, post, stall_n;
    int          cyc, first_w, lat_cyc, b1_end;
    bit          prev_stall, pop_chk;
    beat_t       sv, ob;
    eff = (v.fp == 0) ? 1 : v.fp;
    nb1 = (eff < BP) ? eff : BP;
    gen_pixels(eff, v.pat);
    build_exp(v.base, eff);
    obs_q.delete();
    @(posedge clk); #1;
    avm_waitrequest = 1'b0;
    snk_valid = 1'b1;
    drive_px(0);
    @(negedge clk);
    check({tag, "_idle_ready"}, 64'(snk_ready), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b1; base_addr = v.base; frame_pixels = 24'(v.fp);
    @(posedge clk); #1;
    start = 1'b0; base_addr = 32'hDEAD_0000; frame_pixels = 24'd5;
    cyc = 0; accepted = 0; beats = 0; done = 0; post = 0; stall_n = 0;
    first_w = -1; lat_cyc = -1; b1_end = -1; prev_stall = 0; pop_chk = 0;
    sv = '{default: '0};
    while (cyc < 3000 && !(done > 0 && post >= 4)) begin
      @(negedge clk);
      if (cyc == 0) check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
      if (pop_chk) begin
        check({tag, "_ready_after_pop"}, 64'(snk_ready), 64'd1);
        pop_chk = 0;
      end
      if (prev_stall) begin
        check({tag, "_stall_write"}, 64'(avm_write), 64'd1);
        check({tag, "_stall_addr"}, 64'(avm_address), 64'(sv.addr));
        check({tag, "_stall_bc"}, 64'(avm_burstcount), 64'(sv.bc));
        check({tag, "_stall_data"}, avm_writedata, sv.data);
      end
      prev_stall = avm_write && avm_waitrequest;
      sv.addr = avm_address; sv.bc = avm_burstcount; sv.data = avm_writedata;
      if (avm_write) begin
        check({tag, "_byteenable"}, 64'(avm_byteenable), 64'hFF);
        if (first_w < 0) first_w = cyc;
      end
      if (avm_write && !avm_waitrequest) begin
        ob.addr = avm_address; ob.bc = avm_burstcount; ob.data = avm_writedata;
        obs_q.push_back(ob);
        beats++;
        if (beats == 3 * nb1) b1_end = cyc;
        if (v.wmode == 3 && beats == 3) pop_chk = 1;
      end
      if (snk_valid && snk_ready) begin
        accepted++;
        if (accepted == nb1) lat_cyc = cyc;
      end
      if (frame_done) done++;
      if (done > 0) post++;
      if (v.wmode == 3 && cyc == 79) begin
        check({tag, "_bp_accepted"}, 64'(accepted), 64'(FD));
        check({tag, "_bp_ready_low"}, 64'(snk_ready), 64'd0);
      end
      @(posedge clk); #1;
      snk_valid = (done > 0) ? 1'b0 : (v.gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
      drive_px(accepted);
      if (v.restart && cyc == 10) begin
        start = 1'b1; base_addr = v.base ^ 32'h00FF_0000; frame_pixels = 24'd3;
      end else begin
        start = 1'b0;
      end
      case (v.wmode)
        1: avm_waitrequest = ($urandom_range(0, 2) == 0);
        2: begin
          if (beats == 7 && stall_n < 5 && avm_write) begin
            avm_waitrequest = 1'b1;
            stall_n++;
          end else begin
            avm_waitrequest = 1'b0;
          end
        end
        3: avm_waitrequest = (cyc < 80);
        default: avm_waitrequest = 1'b0;
      endcase
      cyc++;
    end
    snk_valid = 1'b0;
    avm_waitrequest = 1'b0;
    if (done == 0) check({tag, "_frame_done_timeout"}, 64'd0, 64'd1);
    check({tag, "_done_pulses"}, 64'(done), 64'd1);
    @(negedge clk);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_accepted"}, 64'(accepted), 64'(eff));
    check({tag, "_beats"}, 64'(obs_q.size()), 64'(v.exp_beats));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(obs_q[i].addr), 64'(exp_q[i].addr));
      check($sformatf("%s_bc%0d", tag, i), 64'(obs_q[i].bc), 64'(exp_q[i].bc));
      check($sformatf("%s_data%0d", tag, i), obs_q[i].data, exp_q[i].data);
    end
    if (obs_q.size() > 0) begin
      check({tag, "_last_addr"}, 64'(obs_q[$].addr), 64'(v.exp_last_addr));
      check({tag, "_last_bc"}, 64'(obs_q[$].bc), 64'(v.exp_last_bc));
    end
    if (v.chk_lat) begin
      check({tag, "_latency"}, 64'(first_w), 64'(lat_cyc + 2));
      check({tag, "_burst_span"}, 64'(b1_end - first_w), 64'(3 * nb1 - 1));
    end
    if (v.pat && obs_q.size() >= 3) begin
`ifdef GMM_WRITEBACK_CHECKSUM_EN
      check({tag, "_checksum"}, 64'(obs_q[2].data[63:56]), 64'h01);
`else
      check({tag, "_checksum_absent"}, 64'(obs_q[2].data[63:56]), 64'h00);
`endif
    end
  endtask

  vec_t tbl[8];

  initial begin
    int unsigned acc, beats;
    tbl[0] = '{32'h1000, 8,  0, 0, 0, 0, 24,  32'h1000, 8'd24, 1};
    tbl[1] = '{32'h1000, 10, 0, 0, 0, 0, 30,  32'h10C0, 8'd6,  1};
    tbl[2] = '{32'h2000, 16, 2, 0, 0, 0, 48,  32'h20C0, 8'd24, 0};
    tbl[3] = '{32'h0000, 40, 3, 0, 0, 0, 120, 32'h0300, 8'd24, 0};
    tbl[4] = '{32'h4000, 0,  0, 0, 0, 0, 3,   32'h4000, 8'd3,  1};
    tbl[5] = '{32'h5008, 13, 1, 1, 1, 0, 39,  32'h50C8, 8'd15, 0};
    tbl[6] = '{32'h0100, 1,  0, 0, 0, 1, 3,   32'h0100, 8'd3,  1};
    tbl[7] = '{32'h7000, 25, 1, 1, 0, 0, 75,  32'h7240, 8'd3,  0};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; frame_pixels = '0;
    snk_valid = 1'b0; avm_waitrequest = 1'b0;
    snk_u = '0; snk_clusters_num = '0; snk_mem_color = '0; snk_mem_var = '0; snk_mem_w = '0;
    #23;
    check("rst_write", 64'(avm_write), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(snk_ready), 64'd0);
    check("rst_addr", 64'(avm_address), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_frame(tbl[i], $sformatf("v%0d", i));

    // Mid-burst reset: the burst is abandoned and the next frame starts from an empty FIFO.
    gen_pixels(8, 0);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h9000; frame_pixels = 24'd8;
    snk_valid = 1'b1; drive_px(0);
    acc = 0; beats = 0;
    for (int c = 0; c < 200 && beats < 5; c++) begin
      @(negedge clk);
      if (snk_valid && snk_ready) acc++;
      if (avm_write && !avm_waitrequest) beats++;
      @(posedge clk); #1;
      start = 1'b0;
      drive_px(acc);
    end
    check("mid_reset_reached_burst", 64'(beats >= 5), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_write", 64'(avm_write), 64'd0);
    check("mid_rst_data", avm_writedata, 64'd0);
    check("mid_rst_addr", 64'(avm_address), 64'd0);
    check("mid_rst_bc", 64'(avm_burstcount), 64'd0);
    check("mid_rst_be", 64'(avm_byteenable), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(frame_done), 64'd0);
    check("mid_rst_ready", 64'(snk_ready), 64'd0);
    snk_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    check("mid_rst_hold_write", 64'(avm_write), 64'd0);
    rst_n = 1'b1;
    run_frame(tbl[1], "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
